// File: rtl/vt_escape_decoder.sv
// Receive-side terminal stream parser: turns host bytes (printables, C0
// controls, ESC / SS3 / CSI sequences) into one decoded command per accepted
// byte or completed sequence, held in a single output register.
module vt_escape_decoder #(
  parameter int PARAM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_low,
  output logic                   character_ready,
  input  logic                   character_valid,
  input  logic [7:0]             character_byte,
  input  logic                   command_ready,
  output logic                   command_valid,
  output logic [2:0]             command_kind,
  output logic [7:0]             command_final,
  output logic [PARAM_WIDTH-1:0] command_param0,
  output logic [PARAM_WIDTH-1:0] command_param1,
  output logic [1:0]             command_count,
  output logic                   command_private
);

  localparam logic [2:0] KIND_PRINT   = 3'd0;
  localparam logic [2:0] KIND_CONTROL = 3'd1;
  localparam logic [2:0] KIND_ESC     = 3'd2;
  localparam logic [2:0] KIND_SS3     = 3'd3;
  localparam logic [2:0] KIND_CSI     = 3'd4;

  localparam logic [PARAM_WIDTH-1:0] PARAM_MAX = {PARAM_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, ESCAPE, SS3, CSI} state_t;

  // Decimal accumulate p*10+d in a widened word, clamped to the parameter range.
  function automatic logic [PARAM_WIDTH-1:0] sat_accum(input logic [PARAM_WIDTH-1:0] p,
                                                       input logic [3:0] d);
    logic [PARAM_WIDTH+3:0] wide;
    wide = ({4'b0000, p} << 3) + ({4'b0000, p} << 1) + {{PARAM_WIDTH{1'b0}}, d};
    if (wide > {4'b0000, PARAM_MAX}) return PARAM_MAX;
    else return wide[PARAM_WIDTH-1:0];
  endfunction

  state_t                  state, state_n;
  logic [PARAM_WIDTH-1:0]  param0, param0_n, param1, param1_n;
  logic [1:0]              idx, idx_n, cnt, cnt_n;
  logic                    priv, priv_n, malformed, malformed_n, seen, seen_n;
  logic                    accept, emit, emit_csi;
  logic [2:0]              emit_kind;
  logic                    is_esc, is_cancel, is_c0, is_del, is_high, is_digit;

  assign character_ready = !command_valid || command_ready;
  assign accept          = character_valid && character_ready;

  assign is_esc    = (character_byte == 8'h1B);
  assign is_cancel = (character_byte == 8'h18) || (character_byte == 8'h1A);
  assign is_c0     = (character_byte < 8'h20) && !is_esc;
  assign is_del    = (character_byte == 8'h7F);
  assign is_high   = character_byte[7];
  assign is_digit  = (character_byte >= 8'h30) && (character_byte <= 8'h39);

  // Parser state and partial CSI context; a reset mid-sequence discards it.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state     <= IDLE;
      param0    <= '0;
      param1    <= '0;
      idx       <= 2'd0;
      cnt       <= 2'd0;
      priv      <= 1'b0;
      malformed <= 1'b0;
      seen      <= 1'b0;
    end else begin
      state     <= state_n;
      param0    <= param0_n;
      param1    <= param1_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      priv      <= priv_n;
      malformed <= malformed_n;
      seen      <= seen_n;
    end
  end

  // Next-state and command decode for the byte accepted this cycle.
  always_comb begin
    state_n     = state;
    param0_n    = param0;
    param1_n    = param1;
    idx_n       = idx;
    cnt_n       = cnt;
    priv_n      = priv;
    malformed_n = malformed;
    seen_n      = seen;
    emit        = 1'b0;
    emit_csi    = 1'b0;
    emit_kind   = KIND_PRINT;
    if (accept) begin
      if (state == IDLE) begin
        if (is_esc) begin
          state_n = ESCAPE;
        end else if (is_c0 || is_del) begin
          emit      = 1'b1;
          emit_kind = KIND_CONTROL;
        end else begin
          emit      = 1'b1;
          emit_kind = KIND_PRINT;
        end
      end else if (is_esc) begin
        state_n = ESCAPE;
      end else if (is_cancel) begin
        state_n = IDLE;
      end else if (is_c0) begin
        // Controls embedded in a sequence execute without disturbing it.
        emit      = 1'b1;
        emit_kind = KIND_CONTROL;
      end else if (is_del) begin
        state_n = state;
      end else if (is_high) begin
        state_n = IDLE;
      end else begin
        unique case (state)
          ESCAPE: begin
            if (character_byte == 8'h5B) begin
              state_n     = CSI;
              param0_n    = '0;
              param1_n    = '0;
              idx_n       = 2'd0;
              cnt_n       = 2'd0;
              priv_n      = 1'b0;
              malformed_n = 1'b0;
              seen_n      = 1'b0;
            end else if (character_byte == 8'h4F) begin
              state_n = SS3;
            end else begin
              emit      = 1'b1;
              emit_kind = KIND_ESC;
              state_n   = IDLE;
            end
          end
          SS3: begin
            if (character_byte >= 8'h40) begin
              emit      = 1'b1;
              emit_kind = KIND_SS3;
            end
            state_n = IDLE;
          end
          CSI: begin
            if (character_byte >= 8'h40) begin
              emit      = !malformed;
              emit_csi  = !malformed;
              emit_kind = KIND_CSI;
              state_n   = IDLE;
            end else begin
              seen_n = 1'b1;
              if (is_digit) begin
                // Third and later parameters are parsed but discarded.
                if (!idx[1]) begin
                  if (idx == 2'd0) param0_n = sat_accum(param0, character_byte[3:0]);
                  else             param1_n = sat_accum(param1, character_byte[3:0]);
                  if (cnt < idx + 2'd1) cnt_n = idx + 2'd1;
                end
              end else if (character_byte == 8'h3B) begin
                if (!idx[1]) idx_n = idx + 2'd1;
                cnt_n = 2'd2;
              end else if ((character_byte == 8'h3F) && !seen) begin
                priv_n = 1'b1;
              end else begin
                malformed_n = 1'b1;
              end
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Command register: loads on an emitting accept, drains on consumer handshake.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      command_valid   <= 1'b0;
      command_kind    <= 3'd0;
      command_final   <= 8'd0;
      command_param0  <= '0;
      command_param1  <= '0;
      command_count   <= 2'd0;
      command_private <= 1'b0;
    end else if (emit) begin
      command_valid   <= 1'b1;
      command_kind    <= emit_kind;
      command_final   <= character_byte;
      command_param0  <= emit_csi ? param0 : '0;
      command_param1  <= emit_csi ? param1 : '0;
      command_count   <= emit_csi ? cnt : 2'd0;
      command_private <= emit_csi ? priv : 1'b0;
    end else if (command_ready) begin
      command_valid <= 1'b0;
    end
  end

endmodule
